// File: rtl/exception_sequencer_pkg.sv
// Shared constants for the exception sequencer: address-mux selects,
// cause encodings, FSM state codes and small decode helpers.
package exception_sequencer_pkg;

   // Address mux selects
   localparam logic [2:0] SEL_PC  = 3'b000;
   localparam logic [2:0] SEL_253 = 3'b001;  // invalid opcode vector
   localparam logic [2:0] SEL_254 = 3'b010;  // overflow vector
   localparam logic [2:0] SEL_255 = 3'b011;  // divide-by-zero vector

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_OPCODE   = 2'b01,
      CAUSE_OVERFLOW = 2'b10,
      CAUSE_DIV_ZERO = 2'b11
   } cause_t;

   // FSM state codes; the remaining three encodings are illegal and recover to IDLE
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SAVE_EPC  = 3'd1;
   localparam logic [2:0] ST_FETCH_VEC = 3'd2;
   localparam logic [2:0] ST_LOAD_PC   = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   // Fixed priority: invalid opcode beats overflow beats divide-by-zero
   function automatic cause_t pick_cause(input logic inv, input logic ovf, input logic dz);
      cause_t c;
      if (inv)      c = CAUSE_OPCODE;
      else if (ovf) c = CAUSE_OVERFLOW;
      else if (dz)  c = CAUSE_DIV_ZERO;
      else          c = CAUSE_NONE;
      return c;
   endfunction

   // Handler-vector byte address for a latched cause
   function automatic logic [2:0] vector_select(input cause_t c);
      logic [2:0] s;
      case (c)
         CAUSE_OPCODE:   s = SEL_253;
         CAUSE_OVERFLOW: s = SEL_254;
         CAUSE_DIV_ZERO: s = SEL_255;
         default:        s = SEL_PC;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/exception_sequencer_if.sv
// Bus between main control / datapath and the exception sequencer.
// The master side is the sequencer: it samples the control and flag inputs
// and drives the address mux select, memory read and PC/EPC strobes.
// There is no valid/ready pair here: exc_check qualifies the flags for one
// cycle, and busy tells main control to stall while the sequencer owns the bus.
interface exception_sequencer_if;
   logic       exc_check;
   logic       invalid_opcode;
   logic       overflow;
   logic       div_zero;
   logic [2:0] ctrl_address_control;
   logic       ctrl_mem_read;
   logic [2:0] address_control;
   logic       mem_read;
   logic       epc_write;
   logic       pc_write;
   logic       pc_src_exc;
   logic       busy;
   logic       done;
   logic [1:0] cause;
   logic [2:0] dbg_state;  // current FSM state, for debug and checkers

   modport master (
      input  exc_check, invalid_opcode, overflow, div_zero,
      input  ctrl_address_control, ctrl_mem_read,
      output address_control, mem_read, epc_write, pc_write, pc_src_exc,
      output busy, done, cause, dbg_state
   );

   modport slave (
      output exc_check, invalid_opcode, overflow, div_zero,
      output ctrl_address_control, ctrl_mem_read,
      input  address_control, mem_read, epc_write, pc_write, pc_src_exc,
      input  busy, done, cause, dbg_state
   );
endinterface

// File: rtl/exception_sequencer_wait_counter.sv
// 3-bit down counter with synchronous load and a zero flag; stops at zero.
module exception_sequencer_wait_counter (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [2:0] load_value,
   input  logic       dec,
   output logic       zero
);

   logic [2:0] count;

   // Load has priority over decrement; never wraps below zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                    count <= 3'd0;
      else if (load)                   count <= load_value;
      else if (dec && count != 3'd0)   count <= count - 3'd1;
   end

   assign zero = (count == 3'd0);

endmodule

// File: rtl/exception_sequencer.sv
// Exception sequencer: on an accepted exception it takes the address mux
// away from main control, saves EPC, reads the handler-vector byte and loads
// the PC from it. Otherwise address select and memory read pass straight through.
module exception_sequencer
   import exception_sequencer_pkg::*;
#(
   parameter int MEM_LAT = 2  // memory read wait cycles, 1..7
) (
   input  logic                  clk,
   input  logic                  reset_n,
   exception_sequencer_if.master bus
);

   localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

   logic [2:0] state, state_next;
   cause_t     cause_q, cause_next;
   logic       cnt_zero;
   logic [2:0] vec_sel;

   // Counts the memory wait cycles of FETCH_VEC; loaded while in SAVE_EPC
   exception_sequencer_wait_counter u_wait_counter (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (state == ST_SAVE_EPC),
      .load_value (LAT_LOAD),
      .dec        (state == ST_FETCH_VEC),
      .zero       (cnt_zero)
   );

   assign vec_sel = vector_select(cause_q);

   // Next state and cause; flags only matter in IDLE while exc_check is high
   always_comb begin
      state_next = state;
      cause_next = cause_q;
      case (state)
         ST_IDLE: begin
            if (bus.exc_check && (bus.invalid_opcode || bus.overflow || bus.div_zero)) begin
               state_next = ST_SAVE_EPC;
               cause_next = pick_cause(bus.invalid_opcode, bus.overflow, bus.div_zero);
            end
         end
         ST_SAVE_EPC:  state_next = ST_FETCH_VEC;
         ST_FETCH_VEC: if (cnt_zero) state_next = ST_LOAD_PC;
         ST_LOAD_PC:   state_next = ST_DONE;
         ST_DONE:      state_next = ST_IDLE;
         default:      state_next = ST_IDLE;
      endcase
   end

   // State and cause registers; cause stays latched until the next exception
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         cause_q <= CAUSE_NONE;
      end else begin
         state   <= state_next;
         cause_q <= cause_next;
      end
   end

   // Output decode from the state register; pass-through outside the busy states
   always_comb begin
      bus.address_control = bus.ctrl_address_control;
      bus.mem_read        = bus.ctrl_mem_read;
      bus.epc_write       = 1'b0;
      bus.pc_write        = 1'b0;
      bus.pc_src_exc      = 1'b0;
      bus.busy            = 1'b0;
      bus.done            = 1'b0;
      case (state)
         ST_SAVE_EPC: begin
            bus.address_control = SEL_PC;
            bus.mem_read        = 1'b0;
            bus.epc_write       = 1'b1;
            bus.busy            = 1'b1;
         end
         ST_FETCH_VEC: begin
            bus.address_control = vec_sel;
            bus.mem_read        = 1'b1;
            bus.busy            = 1'b1;
         end
         ST_LOAD_PC: begin
            bus.address_control = vec_sel;
            bus.mem_read        = 1'b0;
            bus.pc_write        = 1'b1;
            bus.pc_src_exc      = 1'b1;
            bus.busy            = 1'b1;
         end
         ST_DONE: bus.done = 1'b1;
         default: ;
      endcase
   end

   assign bus.cause     = cause_q;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: scripted cycles push the expected output
// vector per cycle; a negedge monitor pops and compares.
module tb_exception_sequencer;
   import exception_sequencer_pkg::*;

   localparam int W = 11;  // {addr[2:0], mem_read, epc, pc_write, pc_src, busy, done, cause[1:0]}

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic use_lat1 = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   logic [W-1:0] exp_q[$];
   string        tag_q[$];

   always #5 clk = ~clk;

   exception_sequencer_if bus2();
   exception_sequencer_if bus1();

   exception_sequencer #(.MEM_LAT(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));
   exception_sequencer #(.MEM_LAT(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

   // Both builds see identical stimulus
   assign bus1.exc_check            = bus2.exc_check;
   assign bus1.invalid_opcode       = bus2.invalid_opcode;
   assign bus1.overflow             = bus2.overflow;
   assign bus1.div_zero             = bus2.div_zero;
   assign bus1.ctrl_address_control = bus2.ctrl_address_control;
   assign bus1.ctrl_mem_read        = bus2.ctrl_mem_read;

   logic [W-1:0] obs2, obs1;
   assign obs2 = {bus2.address_control, bus2.mem_read, bus2.epc_write, bus2.pc_write,
                  bus2.pc_src_exc, bus2.busy, bus2.done, bus2.cause};
   assign obs1 = {bus1.address_control, bus1.mem_read, bus1.epc_write, bus1.pc_write,
                  bus1.pc_src_exc, bus1.busy, bus1.done, bus1.cause};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b, expected %b", tag, got[W-1:0], exp[W-1:0]);
   endtask

   function automatic logic [W-1:0] pack(input logic [2:0] a, input logic rd, input logic epc,
                                         input logic pcw, input logic pcs, input logic bsy,
                                         input logic dn, input logic [1:0] c);
      return {a, rd, epc, pcw, pcs, bsy, dn, c};
   endfunction

   function automatic logic [W-1:0] pass_v(input logic [2:0] a, input logic rd, input logic [1:0] c);
      return pack(a, rd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c);
   endfunction

   // One cycle: drive inputs just after the edge and queue what the outputs must show
   task automatic step(input string tag, input logic rst, input logic [2:0] caddr, input logic crd,
                       input logic exc, input logic inv, input logic ovf, input logic dz,
                       input logic [W-1:0] exp_v);
      @(posedge clk);
      #1;
      reset_n                   = rst;
      bus2.ctrl_address_control = caddr;
      bus2.ctrl_mem_read        = crd;
      bus2.exc_check            = exc;
      bus2.invalid_opcode       = inv;
      bus2.overflow             = ovf;
      bus2.div_zero             = dz;
      exp_q.push_back(exp_v);
      tag_q.push_back(tag);
   endtask

   // Full exception sequence; noise raises flags in every busy/DONE cycle
   task automatic run_exc(input int lat, input logic inv, input logic ovf, input logic dz,
                          input logic [2:0] sel, input logic [1:0] c, input logic [1:0] prev_c,
                          input logic noise);
      step("accept", 1'b1, 3'b100, 1'b1, 1'b1, inv, ovf, dz, pass_v(3'b100, 1'b1, prev_c));
      step("save_epc", 1'b1, 3'b110, 1'b1, noise, 1'b0, noise, 1'b0,
           pack(SEL_PC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c));
      for (int i = 0; i < lat; i++)
         step("fetch_vec", 1'b1, 3'b111, 1'b0, noise, 1'b0, noise, 1'b0,
              pack(sel, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c));
      step("load_pc", 1'b1, 3'b101, 1'b1, noise, noise, 1'b0, 1'b0,
           pack(sel, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, c));
      step("done", 1'b1, 3'b010, 1'b1, noise, 1'b0, noise, noise,
           pack(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c));
      step("back_idle", 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pass_v(3'b100, 1'b1, c));
      step("idle_hold", 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pass_v(3'b001, 1'b0, c));
   endtask

   // Scoreboard monitor: compares away from the active edge
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         string        t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check_eq(t, use_lat1 ? obs1 : obs2, e);
      end
   end

   initial begin
      logic [2:0] ra;
      logic       rr;
      bus2.exc_check            = 1'b0;
      bus2.invalid_opcode       = 1'b0;
      bus2.overflow             = 1'b0;
      bus2.div_zero             = 1'b0;
      bus2.ctrl_address_control = 3'b101;
      bus2.ctrl_mem_read        = 1'b0;

      // Reset state: idle pass-through, strobes low, cause 00
      step("reset", 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pass_v(3'b101, 1'b0, 2'b00));
      step("reset", 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pass_v(3'b101, 1'b0, 2'b00));

      // Pass-through
      for (int i = 0; i < 3; i++)
         step("pass_100", 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pass_v(3'b100, 1'b1, 2'b00));
      for (int i = 0; i < 6; i++) begin
         ra = 3'($urandom_range(0, 7));
         rr = 1'($urandom_range(0, 1));
         step("pass_rand", 1'b1, ra, rr, 1'b0, 1'b0, 1'b0, 1'b0, pass_v(ra, rr, 2'b00));
      end

      // Gating: flags without exc_check, and exc_check without flags
      for (int i = 0; i < 3; i++)
         step("gate_no_check", 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, pass_v(3'b100, 1'b1, 2'b00));
      for (int i = 0; i < 2; i++)
         step("gate_no_flag", 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, pass_v(3'b100, 1'b1, 2'b00));
      step("gate_idle", 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pass_v(3'b100, 1'b1, 2'b00));

      // Overflow, vector 254
      run_exc(2, 1'b0, 1'b1, 1'b0, SEL_254, 2'b10, 2'b00, 1'b0);
      // All flags together: invalid opcode wins, vector 253
      run_exc(2, 1'b1, 1'b1, 1'b1, SEL_253, 2'b01, 2'b10, 1'b0);
      // Divide-by-zero with flags raised while busy and in DONE: all dropped
      run_exc(2, 1'b0, 1'b0, 1'b1, SEL_255, 2'b11, 2'b01, 1'b1);

      // Reset during the second FETCH_VEC cycle
      step("rst_accept", 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, pass_v(3'b100, 1'b1, 2'b11));
      step("rst_save", 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
           pack(SEL_PC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10));
      step("rst_fetch1", 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
           pack(SEL_254, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10));
      step("rst_mid", 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pass_v(3'b011, 1'b0, 2'b00));
      for (int i = 0; i < 4; i++)
         step("rst_release", 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pass_v(3'b100, 1'b1, 2'b00));

      // One-cycle memory latency build: single vector read then PC load
      @(negedge clk);
      #1;
      use_lat1 = 1'b1;
      step("lat1_idle", 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pass_v(3'b100, 1'b1, 2'b00));
      run_exc(1, 1'b0, 1'b0, 1'b1, SEL_255, 2'b11, 2'b00, 1'b0);

      @(negedge clk);
      #1;
      check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
